// File: rtl/muldiv_unit_if.sv
// Issue/write-back bundle between the decode stage and the iterative
// multiply/divide unit.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      rd_in;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, funct3, op_a, op_b, rd_in, flush,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, funct3, op_a, op_b, rd_in, flush,
    output busy, done, result, rd_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M execute unit: shift-add multiply / restoring divide on
// operand magnitudes, fixed XLEN+2 cycle latency, sign fix-up at the end.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] F_MUL    = 3'd0;
  localparam logic [2:0] F_MULH   = 3'd1;
  localparam logic [2:0] F_MULHSU = 3'd2;
  localparam logic [2:0] F_MULHU  = 3'd3;
  localparam logic [2:0] F_DIV    = 3'd4;
  localparam logic [2:0] F_DIVU   = 3'd5;
  localparam logic [2:0] F_REM    = 3'd6;
  localparam logic [2:0] F_REMU   = 3'd7;

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO_W   = {XLEN{1'b0}};

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v,
                                               input logic            neg);
    cond_neg = neg ? (-v) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg2(input logic [2*XLEN-1:0] v,
                                                  input logic              neg);
    cond_neg2 = neg ? (-v) : v;
  endfunction

  state_t              state_r;
  state_t              state_nx_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [2:0]          f3_r;
  logic [XLEN-1:0]     a_raw_r;
  logic [XLEN-1:0]     mag_a_r;
  logic [XLEN-1:0]     mag_b_r;
  logic                neg_a_r;
  logic                neg_b_r;
  logic                div_zero_r;
  logic                ovf_r;
  logic [4:0]          rd_pend_r;
  logic [2*XLEN-1:0]   acc_r;
  logic                busy_r;
  logic                done_r;
  logic [XLEN-1:0]     result_r;
  logic [4:0]          rd_out_r;

  logic                accept_s;
  logic                signed_a_s;
  logic                signed_b_s;
  logic                is_div_s;
  logic                neg_a_s;
  logic                neg_b_s;
  logic [XLEN-1:0]     mag_a_s;
  logic [XLEN-1:0]     mag_b_s;
  logic [XLEN:0]       mul_sum_s;
  logic [XLEN:0]       div_shl_s;
  logic [XLEN+1:0]     div_diff_s;
  logic [2*XLEN-1:0]   acc_nx_s;
  logic [2*XLEN-1:0]   prod_s;
  logic [XLEN-1:0]     quot_s;
  logic [XLEN-1:0]     rem_s;
  logic [XLEN-1:0]     result_nx_s;

  assign accept_s = (state_r == IDLE) && bus.start && !bus.flush;

  // Operand signedness decode and magnitude extraction at issue
  always_comb begin
    signed_a_s = 1'b0;
    signed_b_s = 1'b0;
    is_div_s   = bus.funct3[2];
    case (bus.funct3)
      F_MULH, F_DIV, F_REM: begin
        signed_a_s = 1'b1;
        signed_b_s = 1'b1;
      end
      F_MULHSU: begin
        signed_a_s = 1'b1;
        signed_b_s = 1'b0;
      end
      default: begin
        signed_a_s = 1'b0;
        signed_b_s = 1'b0;
      end
    endcase
    neg_a_s = signed_a_s && bus.op_a[XLEN-1];
    neg_b_s = signed_b_s && bus.op_b[XLEN-1];
    mag_a_s = cond_neg(bus.op_a, neg_a_s);
    mag_b_s = cond_neg(bus.op_b, neg_b_s);
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nx_s = CALC;
        end else begin
          state_nx_s = IDLE;
        end
      end
      CALC: begin
        if (bus.flush) begin
          state_nx_s = IDLE;
        end else if (cnt_r == {CNT_W{1'b1}}) begin
          state_nx_s = FIX;
        end else begin
          state_nx_s = CALC;
        end
      end
      FIX: begin
        if (bus.flush) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // One shift-add or restoring-divide step on the shared accumulator.
  // Divide keeps {remainder, dividend/quotient} so the quotient shifts in at bit 0.
  always_comb begin
    mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} +
                 (acc_r[0] ? {1'b0, mag_a_r} : {(XLEN+1){1'b0}});
    div_shl_s  = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
    div_diff_s = {1'b0, div_shl_s} - {2'b00, mag_b_r};
    if (f3_r[2]) begin
      if (div_diff_s[XLEN+1]) begin
        acc_nx_s = {div_shl_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
      end else begin
        acc_nx_s = {div_diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
      end
    end else begin
      acc_nx_s = {mul_sum_s, acc_r[XLEN-1:1]};
    end
  end

  // Sign correction and result selection, with divide special cases overriding
  always_comb begin
    prod_s = cond_neg2(acc_r, neg_a_r ^ neg_b_r);
    quot_s = cond_neg(acc_r[XLEN-1:0], neg_a_r ^ neg_b_r);
    rem_s  = cond_neg(acc_r[2*XLEN-1:XLEN], neg_a_r);
    case (f3_r)
      F_MUL:                     result_nx_s = prod_s[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU: result_nx_s = prod_s[2*XLEN-1:XLEN];
      F_DIV: begin
        if (div_zero_r) begin
          result_nx_s = ALL_ONES;
        end else if (ovf_r) begin
          result_nx_s = MIN_NEG;
        end else begin
          result_nx_s = quot_s;
        end
      end
      F_DIVU: begin
        if (div_zero_r) begin
          result_nx_s = ALL_ONES;
        end else begin
          result_nx_s = quot_s;
        end
      end
      F_REM: begin
        if (div_zero_r) begin
          result_nx_s = a_raw_r;
        end else if (ovf_r) begin
          result_nx_s = ZERO_W;
        end else begin
          result_nx_s = rem_s;
        end
      end
      F_REMU: begin
        if (div_zero_r) begin
          result_nx_s = a_raw_r;
        end else begin
          result_nx_s = rem_s;
        end
      end
      default: result_nx_s = ZERO_W;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Operand capture, iteration counter and accumulator
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r      <= {CNT_W{1'b0}};
      f3_r       <= 3'd0;
      a_raw_r    <= ZERO_W;
      mag_a_r    <= ZERO_W;
      mag_b_r    <= ZERO_W;
      neg_a_r    <= 1'b0;
      neg_b_r    <= 1'b0;
      div_zero_r <= 1'b0;
      ovf_r      <= 1'b0;
      rd_pend_r  <= 5'd0;
      acc_r      <= {(2*XLEN){1'b0}};
    end else if (accept_s) begin
      cnt_r      <= {CNT_W{1'b0}};
      f3_r       <= bus.funct3;
      a_raw_r    <= bus.op_a;
      mag_a_r    <= mag_a_s;
      mag_b_r    <= mag_b_s;
      neg_a_r    <= neg_a_s;
      neg_b_r    <= neg_b_s;
      div_zero_r <= (bus.op_b == ZERO_W);
      ovf_r      <= (bus.op_a == MIN_NEG) && (bus.op_b == ALL_ONES);
      rd_pend_r  <= bus.rd_in;
      acc_r      <= {ZERO_W, (is_div_s ? mag_a_s : mag_b_s)};
    end else if ((state_r == CALC) && !bus.flush) begin
      cnt_r      <= cnt_r + CNT_W'(1);
      acc_r      <= acc_nx_s;
    end else begin
      cnt_r      <= cnt_r;
      acc_r      <= acc_r;
    end
  end

  // Registered handshake and write-back outputs; result only moves on a completed FIX
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= ZERO_W;
      rd_out_r <= 5'd0;
    end else begin
      busy_r <= (state_nx_s != IDLE);
      done_r <= (state_nx_s == DONE);
      if ((state_r == FIX) && !bus.flush) begin
        result_r <= result_nx_s;
        rd_out_r <= rd_pend_r;
      end else begin
        result_r <= result_r;
        rd_out_r <= rd_out_r;
      end
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.result = result_r;
  assign bus.rd_out = rd_out_r;

endmodule
